// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module  : bcd_pkg
//  Brief   : Shared BCD digit constants and converter state encoding.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ERR   = 2'd2
  } bcd_state_e;

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_to_bin_digit_adjust.sv
// ============================================================================
//  Module  : bcd_digit_adjust
//  Brief   : One BCD digit correction step of reverse double-dabble.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i - BCD_ADJ_SUB) : digit_i;

endmodule : bcd_digit_adjust

`default_nettype wire

// File: rtl/bcd_to_bin.sv
// ============================================================================
//  Module  : bcd_to_bin
//  Brief   : Multi-cycle packed-BCD to binary converter, one bit per clock.
//            Define BCD_TO_BIN_CHECK_EN to enable the digit range check/ERR.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic                start,
  input  logic [4*DIGITS-1:0] BCD,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    binary,
  output logic                error
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  bcd_state_e         state_q, state_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   binary_q, binary_d;
  logic               error_q, error_d;

  logic [SCR_W-1:0]   w_shifted;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [SCR_W-1:0]   w_scratch_next;
  logic               w_bcd_bad;

  assign w_shifted = scratch_q >> 1;

  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      bcd_digit_adjust u_adj (
        .digit_i (w_shifted[BIN_W + BCD_DIGIT_W*d +: BCD_DIGIT_W]),
        .digit_o (w_bcd_adj[BCD_DIGIT_W*d +: BCD_DIGIT_W])
      );
    end : g_digit
  endgenerate

  assign w_scratch_next = {w_bcd_adj, w_shifted[BIN_W-1:0]};

`ifdef BCD_TO_BIN_CHECK_EN
  logic [DIGITS-1:0] w_digit_bad;
  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_check
      assign w_digit_bad[d] = (BCD[BCD_DIGIT_W*d +: BCD_DIGIT_W] > BCD_DIGIT_MAX);
    end : g_check
  endgenerate
  assign w_bcd_bad = |w_digit_bad;
`else
  assign w_bcd_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    binary_d  = binary_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          scratch_d = {BCD, {BIN_W{1'b0}}};
          count_d   = '0;
          busy_d    = 1'b1;
          state_d   = w_bcd_bad ? ST_ERR : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = w_scratch_next;
        count_d   = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          binary_d = w_scratch_next[BIN_W-1:0];
          done_d   = 1'b1;
          error_d  = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
`ifdef BCD_TO_BIN_CHECK_EN
      // Dwell two clocks so the error done lands two edges after acceptance.
      ST_ERR: begin
        count_d = count_q + 1'b1;
        if (count_q != '0) begin
          binary_d = '0;
          done_d   = 1'b1;
          error_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q   <= ST_IDLE;
      scratch_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      binary_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      binary_q  <= binary_d;
      error_q   <= error_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = binary_q;
  assign error  = error_q;

endmodule : bcd_to_bin

`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
// ============================================================================
//  Module  : tb_bcd_to_bin
//  Brief   : Self-checking bench for bcd_to_bin against a decimal-value model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_bin;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;
  localparam int LIMIT  = 4 * BIN_W + 8;

  logic                clk;
  logic                rstn;
  logic                start;
  logic [4*DIGITS-1:0] bcd;
  logic                busy;
  logic                done;
  logic [BIN_W-1:0]    binary;
  logic                error;

  int total;
  int bad;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rstn),
    .start      (start),
    .BCD        (bcd),
    .busy       (busy),
    .done       (done),
    .binary     (binary),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal value of a packed BCD word, digit 0 least significant.
  function automatic int bcd_value(input logic [4*DIGITS-1:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [4*DIGITS-1:0] rand_bcd();
    logic [4*DIGITS-1:0] b;
    for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge; returns just after the accepting edge.
  task automatic pulse_start(input logic [4*DIGITS-1:0] v);
    bcd   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after acceptance until done; k=-1 on timeout.
  task automatic wait_done(output int k, output int busy_cnt);
    busy_cnt = busy ? 1 : 0;
    k = -1;
    for (int c = 1; c <= LIMIT; c++) begin
      tick();
      if (done) begin
        k = c;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; bcd = '0;
    repeat (3) tick();
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (error !== 1'b0)  begin bad++; $display("FAIL reset_error: got %b want 0", error); end
    total++; if (binary !== '0)   begin bad++; $display("FAIL reset_binary: got %0d want 0", binary); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_convert(input logic [4*DIGITS-1:0] v);
    int k, bc, exp;
    exp = bcd_value(v);
    pulse_start(v);
    wait_done(k, bc);
    total++; if (k !== BIN_W)   begin bad++; $display("FAIL lat_%h: got %0d want %0d", v, k, BIN_W); end
    total++; if (bc !== BIN_W)  begin bad++; $display("FAIL busy_%h: got %0d want %0d", v, bc, BIN_W); end
    total++; if (binary !== BIN_W'(exp)) begin bad++; $display("FAIL bin_%h: got %0d want %0d", v, binary, exp); end
    total++; if (error !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flags_%h: got err=%b busy=%b want 0 0", v, error, busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL pulse_%h: got done=%b want 0", v, done); end
    total++; if (binary !== BIN_W'(exp)) begin bad++; $display("FAIL hold_%h: got %0d want %0d", v, binary, exp); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) test_convert(rand_bcd());
  endtask

  task automatic test_back_to_back();
    int k, bc;
    pulse_start(8'h42);
    wait_done(k, bc);
    total++; if (binary !== BIN_W'(42)) begin bad++; $display("FAIL b2b_first: got %0d want 42", binary); end
    pulse_start(8'h15);  // start high during the done cycle
    wait_done(k, bc);
    total++; if (k !== BIN_W) begin bad++; $display("FAIL b2b_lat: got %0d want %0d", k, BIN_W); end
    total++; if (binary !== BIN_W'(15)) begin bad++; $display("FAIL b2b_bin: got %0d want 15", binary); end
    tick();
  endtask

  task automatic test_start_while_busy();
    int k, bc, extra;
    pulse_start(8'h37);
    tick(); tick();
    pulse_start(8'h50);
    wait_done(k, bc);
    total++; if (k !== BIN_W - 3) begin bad++; $display("FAIL busy_start_lat: got %0d want %0d", k, BIN_W - 3); end
    total++; if (binary !== BIN_W'(37)) begin bad++; $display("FAIL busy_start_bin: got %0d want 37", binary); end
    extra = 0;
    for (int c = 0; c < BIN_W + 3; c++) begin tick(); if (done) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL busy_start_extra: got %0d dones want 0", extra); end
  endtask

  task automatic test_held_start();
    int k, bc;
    bcd = 8'h21; start = 1'b1;
    tick();
    wait_done(k, bc);
    total++; if (k !== BIN_W || binary !== BIN_W'(21)) begin bad++; $display("FAIL held_first: got k=%0d bin=%0d want %0d 21", k, binary, BIN_W); end
    wait_done(k, bc);
    total++; if (k !== BIN_W + 1 || binary !== BIN_W'(21)) begin bad++; $display("FAIL held_second: got k=%0d bin=%0d want %0d 21", k, binary, BIN_W + 1); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int k, bc, extra;
    logic [4*DIGITS-1:0] v;
    pulse_start(8'h64);
    tick(); tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || binary !== '0) begin bad++; $display("FAIL midrst: got busy=%b done=%b bin=%0d want 0 0 0", busy, done, binary); end
    extra = 0;
    for (int c = 0; c < BIN_W + 3; c++) begin tick(); if (done || busy) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", extra); end
    v = rand_bcd();
    pulse_start(v);
    wait_done(k, bc);
    total++; if (k !== BIN_W || binary !== BIN_W'(bcd_value(v))) begin bad++; $display("FAIL midrst_after: got k=%0d bin=%0d want %0d %0d", k, binary, BIN_W, bcd_value(v)); end
    tick();
  endtask

  task automatic test_invalid();
    int k, bc;
    pulse_start(8'h1A);
    wait_done(k, bc);
`ifdef BCD_TO_BIN_CHECK_EN
    total++; if (k !== 2) begin bad++; $display("FAIL err_lat: got %0d want 2", k); end
    total++; if (error !== 1'b1 || binary !== '0) begin bad++; $display("FAIL err_flag: got err=%b bin=%0d want 1 0", error, binary); end
`else
    total++; if (k !== BIN_W) begin bad++; $display("FAIL inv_lat: got %0d want %0d", k, BIN_W); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL inv_err: got %b want 0", error); end
`endif
    tick();
    pulse_start(8'h10);
    wait_done(k, bc);
    total++; if (error !== 1'b0 || binary !== BIN_W'(10)) begin bad++; $display("FAIL err_clear: got err=%b bin=%0d want 0 10", error, binary); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_convert(8'h42);
    test_convert(8'h99);
    test_convert(8'h00);
    test_random();
    test_back_to_back();
    test_start_while_busy();
    test_held_start();
    test_reset_mid();
    test_invalid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd_to_bin

`default_nettype wire
